// File: rtl/sseg_scroll_scanner_if.sv
// sseg_scroll_scanner_if: character-RAM read port, step input and display outputs of the scroll scanner.
interface sseg_scroll_scanner_if #(parameter int ADDR_W = 3);
    logic step;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0] ram_dout;
    logic ram_busy;
    logic [7:0] sseg;
    logic [3:0] anode;
    logic frame_valid;
    modport master (input step, ram_dout, output ram_addr, ram_busy, sseg, anode, frame_valid);
    modport slave (output step, ram_dout, input ram_addr, ram_busy, sseg, anode, frame_valid);
endinterface

// File: rtl/sseg_scroll_scanner.sv
// sseg_scroll_scanner: double-buffered 4-digit scrolling window over a character RAM, multiplexed onto sseg/anode.
// Optional SSEG_BLANK_GAP_EN blanks anode for the first 2 cycles of every digit slot.
module sseg_scroll_scanner #(
    parameter int ADDR_W = 3,
    parameter int NUM_CHARS = 8,
    parameter int REFRESH_DIV = 50000
) (
    input logic clk,
    input logic rst,
    sseg_scroll_scanner_if.master bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [ADDR_W:0] NC = (ADDR_W+1)'(NUM_CHARS);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    typedef enum logic {FETCH, SHOW} state_t;
    state_t state, state_nx;
    logic [2:0] k;
    logic [ADDR_W-1:0] base, base_nx, addr_q, addr_calc;
    logic [ADDR_W:0] addr_sum, addr_sub, base_inc;
    logic pending, pending_nx, fetch_addr, advance, blank;
    logic [2:0][7:0] shadow;
    logic [3:0][7:0] disp;
    logic [CW-1:0] cnt;
    logic [1:0] digit;
`ifdef SSEG_BLANK_GAP_EN
    assign blank = cnt < CW'(2);
`else
    assign blank = 1'b0;
`endif
    always_comb begin
        addr_sum = {1'b0, base} + {{(ADDR_W-1){1'b0}}, k[1:0]};
        addr_sub = addr_sum - NC;
        addr_calc = (addr_sum >= NC) ? addr_sub[ADDR_W-1:0] : addr_sum[ADDR_W-1:0];
        base_inc = {1'b0, base} + (ADDR_W+1)'(1);
        fetch_addr = state == FETCH && !k[2];
        advance = state == SHOW && (bus.step || pending);
        state_nx = (state == FETCH) ? (k[2] ? SHOW : FETCH) : (advance ? FETCH : SHOW);
        pending_nx = (state == FETCH) ? (pending || bus.step) : 1'b0;
        base_nx = advance ? ((base_inc == NC) ? '0 : base_inc[ADDR_W-1:0]) : base;
    end
    assign bus.ram_addr = fetch_addr ? addr_calc : addr_q;
    assign bus.ram_busy = state == FETCH && !rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            base <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nx;
            base <= base_nx;
            pending <= pending_nx;
        end
    end
    // shadow fills as a shift register; the fourth character goes straight into disp at the swap
    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
            addr_q <= '0;
            shadow <= '1;
            disp <= '1;
            bus.frame_valid <= 1'b0;
            cnt <= '0;
            digit <= '0;
            bus.anode <= 4'b1111;
            bus.sseg <= 8'hFF;
        end else begin
            k <= fetch_addr ? k + 3'd1 : 3'd0;
            if (fetch_addr) addr_q <= addr_calc;
            if (fetch_addr && k != 3'd0) shadow <= {bus.ram_dout, shadow[2:1]};
            if (state == FETCH && k[2]) begin
                disp <= {bus.ram_dout, shadow};
                bus.frame_valid <= 1'b1;
            end
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
            digit <= (cnt == CNT_MAX) ? digit + 2'd1 : digit;
            bus.anode <= (bus.frame_valid && !blank) ? ~(4'b1000 >> digit) : 4'b1111;
            bus.sseg <= bus.frame_valid ? disp[digit] : 8'hFF;
        end
    end
endmodule

// File: tb/tb_sseg_scroll_scanner.sv
// tb_sseg_scroll_scanner: directed checks of fetch, scroll, pending-step, reset and scan behaviour.
module tb_sseg_scroll_scanner;
`ifdef SSEG_BLANK_GAP_EN
    localparam int DIV = 6;
    localparam bit GAP = 1'b1;
`else
    localparam int DIV = 4;
    localparam bit GAP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int old_base = 0, new_base = 0, swap_t = 0;
    logic [7:0] mem [8] = '{8'hC5, 8'h09, 8'h83, 8'h25, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] chars [4] = '{8'hC5, 8'h09, 8'h83, 8'h25};
    sseg_scroll_scanner_if #(.ADDR_W(3)) bus();
    sseg_scroll_scanner #(.ADDR_W(3), .NUM_CHARS(4), .REFRESH_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // output at cycle t reflects the digit slot of cycle t-1; first frame is valid from cycle 5
    function automatic logic [3:0] exp_anode(input int t);
        int d;
        if (t < 6) return 4'b1111;
        d = ((t - 1) / DIV) % 4;
        if (GAP && ((t - 1) % DIV) < 2) return 4'b1111;
        return ~(4'b1000 >> d);
    endfunction
    function automatic logic [7:0] exp_sseg(input int t);
        int d, b;
        if (t < 6) return 8'hFF;
        d = ((t - 1) / DIV) % 4;
        b = (t >= swap_t) ? new_base : old_base;
        return chars[(b + d) % 4];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.step = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        old_base = 0; new_base = 0; swap_t = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.step = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.anode !== 4'b1111) begin failures++; $display("FAIL reset_anode got=%b exp=1111", bus.anode); end
        checks++; if (bus.sseg !== 8'hFF) begin failures++; $display("FAIL reset_sseg got=%h exp=ff", bus.sseg); end
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
        checks++; if (bus.ram_addr !== 3'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.ram_addr); end
        checks++; if (bus.ram_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.ram_busy); end
    endtask

    task automatic test_initial_fetch();
        int t;
        do_reset();
        repeat (22) begin
            @(negedge clk);
            t = cyc;
            checks++; if (bus.ram_busy !== (t <= 4)) begin failures++; $display("FAIL init_busy t=%0d got=%b", t, bus.ram_busy); end
            if (t < 4) begin
                checks++; if (bus.ram_addr !== 3'(t)) begin failures++; $display("FAIL init_addr t=%0d got=%0d exp=%0d", t, bus.ram_addr, t); end
            end
            checks++; if (bus.frame_valid !== (t >= 5)) begin failures++; $display("FAIL init_fv t=%0d got=%b", t, bus.frame_valid); end
            checks++; if (bus.anode !== exp_anode(t)) begin failures++; $display("FAIL init_anode t=%0d got=%b exp=%b", t, bus.anode, exp_anode(t)); end
            checks++; if (bus.sseg !== exp_sseg(t)) begin failures++; $display("FAIL init_sseg t=%0d got=%h exp=%h", t, bus.sseg, exp_sseg(t)); end
        end
    endtask

    task automatic test_step();
        int s, t;
        s = cyc;
        bus.step = 1'b1;
        old_base = 0; new_base = 1; swap_t = s + 7;
        repeat (30) begin
            @(negedge clk);
            bus.step = 1'b0;
            t = cyc;
            checks++; if (bus.ram_busy !== (t >= s + 1 && t <= s + 5)) begin failures++; $display("FAIL step_busy t=%0d got=%b", t, bus.ram_busy); end
            checks++; if (bus.ram_addr !== 3'((t <= s + 4) ? (t - s) % 4 : 0)) begin failures++; $display("FAIL step_addr t=%0d got=%0d", t, bus.ram_addr); end
            checks++; if (bus.anode !== exp_anode(t)) begin failures++; $display("FAIL step_anode t=%0d got=%b exp=%b", t, bus.anode, exp_anode(t)); end
            checks++; if (bus.sseg !== exp_sseg(t)) begin failures++; $display("FAIL step_sseg t=%0d got=%h exp=%h", t, bus.sseg, exp_sseg(t)); end
        end
    endtask

    task automatic test_wrap();
        int t;
        do_reset();
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.step = 1'b1;
            @(negedge clk);
            bus.step = 1'b0;
            checks++; if (bus.ram_addr !== 3'((i + 1) % 4) || bus.ram_busy !== 1'b1) begin failures++; $display("FAIL wrap_base i=%0d got=%0d/%b exp=%0d/1", i, bus.ram_addr, bus.ram_busy, (i + 1) % 4); end
            repeat (6) @(negedge clk);
        end
        old_base = 0; new_base = 0;
        repeat (20) begin
            @(negedge clk);
            t = cyc;
            checks++; if (bus.anode !== exp_anode(t)) begin failures++; $display("FAIL wrap_anode t=%0d got=%b exp=%b", t, bus.anode, exp_anode(t)); end
            checks++; if (bus.sseg !== exp_sseg(t)) begin failures++; $display("FAIL wrap_sseg t=%0d got=%h exp=%h", t, bus.sseg, exp_sseg(t)); end
        end
    endtask

    // one step in SHOW, then extra steps at offsets a and b; only one follow-up fetch may run
    task automatic test_extra_step(input int a, input int b);
        int s, t;
        do_reset();
        repeat (9) @(negedge clk);
        s = cyc;
        bus.step = 1'b1;
        old_base = 1; new_base = 2; swap_t = s + 13;
        repeat (26) begin
            @(negedge clk);
            t = cyc;
            checks++; if (bus.ram_busy !== ((t >= s + 1 && t <= s + 5) || (t >= s + 7 && t <= s + 11))) begin failures++; $display("FAIL extra_busy a=%0d t=%0d got=%b", a, t - s, bus.ram_busy); end
            if (t >= s + 7) begin
                checks++; if (bus.ram_addr !== 3'((t <= s + 10) ? (t - s - 5) % 4 : 1)) begin failures++; $display("FAIL extra_addr a=%0d t=%0d got=%0d", a, t - s, bus.ram_addr); end
                checks++; if (bus.sseg !== exp_sseg(t)) begin failures++; $display("FAIL extra_sseg a=%0d t=%0d got=%h exp=%h", a, t - s, bus.sseg, exp_sseg(t)); end
            end
            checks++; if (bus.anode !== exp_anode(t)) begin failures++; $display("FAIL extra_anode a=%0d t=%0d got=%b exp=%b", a, t - s, bus.anode, exp_anode(t)); end
            bus.step = (t == s + a || t == s + b);
        end
    endtask

    task automatic test_reset_mid_show();
        int t;
        do_reset();
        repeat (9) @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.anode !== 4'b1111) begin failures++; $display("FAIL mid_anode got=%b exp=1111", bus.anode); end
        checks++; if (bus.sseg !== 8'hFF) begin failures++; $display("FAIL mid_sseg got=%h exp=ff", bus.sseg); end
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL mid_fv got=%b exp=0", bus.frame_valid); end
        checks++; if (bus.ram_addr !== 3'd0 || bus.ram_busy !== 1'b0) begin failures++; $display("FAIL mid_port got=%0d/%b exp=0/0", bus.ram_addr, bus.ram_busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        old_base = 0; new_base = 0; swap_t = 0;
        repeat (14) begin
            @(negedge clk);
            t = cyc;
            checks++; if (bus.ram_busy !== (t <= 4)) begin failures++; $display("FAIL mid_busy t=%0d got=%b", t, bus.ram_busy); end
            if (t < 4) begin
                checks++; if (bus.ram_addr !== 3'(t)) begin failures++; $display("FAIL mid_addr t=%0d got=%0d exp=%0d", t, bus.ram_addr, t); end
            end
            checks++; if (bus.anode !== exp_anode(t)) begin failures++; $display("FAIL mid_scan_anode t=%0d got=%b exp=%b", t, bus.anode, exp_anode(t)); end
            checks++; if (bus.sseg !== exp_sseg(t)) begin failures++; $display("FAIL mid_scan_sseg t=%0d got=%h exp=%h", t, bus.sseg, exp_sseg(t)); end
        end
    endtask

    initial begin
        bus.step = 1'b0;
        test_reset();
        test_initial_fetch();
        test_step();
        test_wrap();
        test_extra_step(2, 3);
        test_extra_step(5, 5);
        test_reset_mid_show();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
